// File: rtl/prbs_pkg.sv
// Shared PRBS31 definitions (x^31 + x^28 + 1). The generator and the checker both use this package,
// so the taps are defined in one place.
//   PRBS_LEN      replica / generator register length
//   TAP_A, TAP_B  feedback taps (the next bit is s[TAP_A] ^ s[TAP_B])
//   state_e       checker state encodings
//   prbs_predict  next-bit prediction from a history register whose s[0] is the newest bit
package prbs_pkg;

  localparam int unsigned PRBS_LEN = 31;
  localparam int unsigned TAP_A    = 30;
  localparam int unsigned TAP_B    = 27;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  function automatic logic prbs_predict(input logic [PRBS_LEN-1:0] s);
    return s[TAP_A] ^ s[TAP_B];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk    clock (posedge)
//   rst    synchronous active-high reset
//   clr    synchronous clear; takes priority over en
//   en     increment by one unless the count is already all-ones
//   count  current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 receive checker. Seeds a local replica from the first 31 valid bits, confirms it against
// LOCK_THRESH consecutive predicted bits, then free-runs the replica and counts bit errors.
// Too many errors inside one WINDOW of valid bits drops lock and restarts seeding.
//   clk        clock (posedge)
//   rst_n      synchronous reset, active HIGH despite the name
//   bit_in     received serial bit
//   bit_valid  bit_in is only sampled when high
//   clear_cnt  synchronous clear of err_count/bit_count; lock state untouched
//   locked     high while in the locked state
//   err_pulse  one-cycle pulse per error detected while locked
//   err_count  saturating count of errors seen while locked
//   bit_count  saturating count of valid bits checked while locked
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_THRESH   = 64,
  parameter int unsigned UNLOCK_THRESH = 8,
  parameter int unsigned WINDOW        = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  state_e              state;
  logic [PRBS_LEN-1:0] s;
  logic [4:0]          seed_cnt;
  logic [7:0]          match_cnt;
  logic [WIN_W-1:0]    win_cnt;
  logic [7:0]          win_err;

  logic       p;
  logic       mismatch;
  logic       win_wrap;
  logic [8:0] match_nxt;
  logic [8:0] win_err_nxt;
  logic       chk_en;

  assign p         = prbs_predict(s);
  assign mismatch  = bit_in ^ p;
  assign match_nxt = {1'b0, match_cnt} + 9'd1;
  assign win_wrap  = (win_cnt == WIN_W'(WINDOW - 1));
  // On the wrapping bit the window error count restarts, and that bit's own error opens the new one.
  assign win_err_nxt = win_wrap ? {8'd0, mismatch} : ({1'b0, win_err} + {8'd0, mismatch});
  assign chk_en      = bit_valid && (state == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= ST_SEED;
      s         <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (bit_valid) begin
        unique case (state)
          ST_SEED: begin
            s        <= {s[PRBS_LEN-2:0], bit_in};
            seed_cnt <= seed_cnt + 5'd1;
            if (seed_cnt == 5'(PRBS_LEN - 1)) begin
              state     <= ST_ACQ;
              match_cnt <= '0;
            end
          end
          ST_ACQ: begin
            // Input is fed back, so a mismatch simply reloads history from the line.
            s <= {s[PRBS_LEN-2:0], bit_in};
            if (!mismatch && (s != '0)) begin
              if (match_nxt == 9'(LOCK_THRESH)) begin
                state     <= ST_LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                win_cnt   <= '0;
                win_err   <= '0;
              end else begin
                match_cnt <= match_nxt[7:0];
              end
            end else begin
              match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            // Free-running replica: a single flipped line bit costs exactly one error.
            s         <= {s[PRBS_LEN-2:0], p};
            err_pulse <= mismatch;
            win_cnt   <= win_cnt + WIN_W'(1);
            if (win_err_nxt == 9'(UNLOCK_THRESH)) begin
              state    <= ST_SEED;
              locked   <= 1'b0;
              seed_cnt <= '0;
              s        <= '0;
              win_err  <= '0;
            end else begin
              win_err <= win_err_nxt[7:0];
            end
          end
          default: begin
            state  <= ST_SEED;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst_n),
    .clr  (clear_cnt),
    .en   (chk_en && mismatch),
    .count(err_count)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_bit_cnt (
    .clk  (clk),
    .rst  (rst_n),
    .clr  (clear_cnt),
    .en   (chk_en),
    .count(bit_count)
  );

endmodule

// File: tb/tb_prbs31_checker.sv
module tb_prbs31_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid;
  logic        clear_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] bit_count;
  logic        locked_s;
  logic        err_pulse_s;
  logic [3:0]  err_count_s;
  logic [3:0]  bit_count_s;

  always #5 clk = ~clk;

  prbs31_checker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .clear_cnt(clear_cnt),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .bit_count(bit_count)
  );

  // Narrow counters, effectively no unlock: used for saturation checks.
  prbs31_checker #(
    .CNT_W        (4),
    .UNLOCK_THRESH(255)
  ) dut_s (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .clear_cnt(clear_cnt),
    .locked   (locked_s),
    .err_pulse(err_pulse_s),
    .err_count(err_count_s),
    .bit_count(bit_count_s)
  );

  localparam int SIG_LOCKED = 0, SIG_PULSE = 1, SIG_ERRC = 2, SIG_BITC = 3;
  localparam int SIG_LOCKED_S = 4, SIG_PULSE_S = 5, SIG_ERRC_S = 6, SIG_BITC_S = 7;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference generator: MSB out, feedback into bit 0.
  logic [30:0] g;

  typedef struct {
    logic        flip;
    logic        valid;
    logic        clr;
    logic        exp_pulse;
    int unsigned exp_errc;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SIG_LOCKED:   return 32'(locked);
      SIG_PULSE:    return 32'(err_pulse);
      SIG_ERRC:     return 32'(err_count);
      SIG_BITC:     return 32'(bit_count);
      SIG_LOCKED_S: return 32'(locked_s);
      SIG_PULSE_S:  return 32'(err_pulse_s);
      SIG_ERRC_S:   return 32'(err_count_s);
      default:      return 32'(bit_count_s);
    endcase
  endfunction

  task automatic expect_val(input string name, input int sig, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Drive one cycle, then check every expectation queued for this cycle.
  task automatic step(input logic b, input logic v, input logic c);
    exp_t        e;
    logic [31:0] act;
    bit_in    = b;
    bit_valid = v;
    clear_cnt = c;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = observe(e.sig);
      vectors++;
      if (act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %0d, expected %0d", e.name, act, e.val);
      end
    end
  endtask

  task automatic gen_bit(output logic b);
    b = g[30];
    g = {g[29:0], g[30] ^ g[27]};
  endtask

  task automatic send_good(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    g     = 31'd1;
    step(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        b;
    int unsigned exp_bc;
    int          cnt;
    int          guard;
    logic        v;

    rst_n     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    clear_cnt = 1'b0;
    g         = 31'd1;

    // Post-lock vectors: flip applied to the generator bit; invalid cycles do not advance it.
    tbl = '{
      '{1'b0, 1'b1, 1'b0, 1'b0, 0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1},
      '{1'b0, 1'b1, 1'b1, 1'b0, 0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 1},
      '{1'b1, 1'b1, 1'b1, 1'b1, 0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 0}
    };

    // Reset state; bit_valid is high during reset to show reset wins.
    expect_val("rst_locked", SIG_LOCKED, 0);
    expect_val("rst_pulse", SIG_PULSE, 0);
    expect_val("rst_errc", SIG_ERRC, 0);
    expect_val("rst_bitc", SIG_BITC, 0);
    do_reset();

    // Clean stream: lock visible after valid bit 95, bit_count = N - 95.
    for (int i = 1; i <= 200; i++) begin
      gen_bit(b);
      expect_val("t1_locked", SIG_LOCKED, 32'(i >= 95));
      if (i == 200) begin
        expect_val("t1_errc", SIG_ERRC, 0);
        expect_val("t1_bitc", SIG_BITC, 105);
      end
      step(b, 1'b1, 1'b0);
    end

    // Single errors, invalid cycles and clear interplay while locked.
    exp_bc = 105;
    foreach (tbl[k]) begin
      if (tbl[k].valid) gen_bit(b);
      else b = 1'($urandom_range(0, 1));
      if (tbl[k].clr) exp_bc = 0;
      else if (tbl[k].valid) exp_bc++;
      expect_val("t2_pulse", SIG_PULSE, 32'(tbl[k].exp_pulse));
      expect_val("t2_errc", SIG_ERRC, tbl[k].exp_errc);
      expect_val("t2_bitc", SIG_BITC, exp_bc);
      expect_val("t2_locked", SIG_LOCKED, 1);
      step(b ^ tbl[k].flip, tbl[k].valid, tbl[k].clr);
    end

    // Eight errors inside one window drop lock; clean stream relocks 95 valid bits later.
    do_reset();
    send_good(100);
    for (int k = 1; k <= 8; k++) begin
      send_good(9);
      gen_bit(b);
      expect_val("t3_locked", SIG_LOCKED, 32'(k < 8));
      expect_val("t3_pulse", SIG_PULSE, 1);
      step(~b, 1'b1, 1'b0);
    end
    for (int i = 1; i <= 95; i++) begin
      gen_bit(b);
      expect_val("t3_relock", SIG_LOCKED, 32'(i == 95));
      if (i == 95) expect_val("t3_errc", SIG_ERRC, 8);
      step(b, 1'b1, 1'b0);
    end

    // All-zero input never locks.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      expect_val("t4_locked", SIG_LOCKED, 0);
      if (i == 1999) expect_val("t4_errc", SIG_ERRC, 0);
      step(1'b0, 1'b1, 1'b0);
    end

    // Gapped valid: lock still follows the 95th valid bit.
    do_reset();
    cnt   = 0;
    guard = 0;
    while (cnt < 95 && guard < 2000) begin
      v = ((guard % 2) == 0) && ($urandom_range(0, 4) != 0);
      if (v) begin
        gen_bit(b);
        cnt++;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      expect_val("t5_gap_locked", SIG_LOCKED, 32'(cnt >= 95));
      step(b, v, 1'b0);
      guard++;
    end
    for (int i = 0; i < 3; i++) begin
      expect_val("t5_gap_hold", SIG_LOCKED, 1);
      step(1'b1, 1'b0, 1'b0);
    end
    send_good(19);
    gen_bit(b);
    expect_val("t5_gap_bitc", SIG_BITC, 20);
    expect_val("t5_gap_errc", SIG_ERRC, 0);
    step(b, 1'b1, 1'b0);

    // Flip at match 40 (valid bit 72). The flipped bit is shifted into the replica, so it later
    // breaks the predictions at bits 100 and 103 (taps 27/30); the clean run then starts at 104
    // and lock follows bit 167.
    do_reset();
    for (int i = 1; i <= 167; i++) begin
      gen_bit(b);
      if (i == 72) b = ~b;
      expect_val("t5_flip_locked", SIG_LOCKED, 32'(i >= 167));
      step(b, 1'b1, 1'b0);
    end

    // Narrow counters saturate at 15; clear on an error cycle wins.
    do_reset();
    send_good(99);
    gen_bit(b);
    expect_val("t6_locked", SIG_LOCKED_S, 1);
    step(b, 1'b1, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      send_good(3);
      gen_bit(b);
      expect_val("t6_errc", SIG_ERRC_S, (k < 15) ? k : 15);
      expect_val("t6_pulse", SIG_PULSE_S, 1);
      expect_val("t6_locked_hold", SIG_LOCKED_S, 1);
      if (k == 20) expect_val("t6_bitc_sat", SIG_BITC_S, 15);
      step(~b, 1'b1, 1'b0);
    end
    gen_bit(b);
    expect_val("t6_clr_errc", SIG_ERRC_S, 0);
    expect_val("t6_clr_bitc", SIG_BITC_S, 0);
    expect_val("t6_clr_pulse", SIG_PULSE_S, 1);
    step(~b, 1'b1, 1'b1);
    gen_bit(b);
    expect_val("t6_post_errc", SIG_ERRC_S, 0);
    expect_val("t6_post_bitc", SIG_BITC_S, 1);
    step(b, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
